// File: rtl/jvm_decode_sequencer.sv
// JVM bytecode fetch/decode sequencer: opcode fetch, WIDE/NOP prefix handling,
// operand streaming and microcode next-address walk. Optional macro: PC_TRACK_EN (byte PC).
module jvm_decode_sequencer #(
  parameter int         PARAM_LEN   = 3,
  parameter int         ADR_W       = 8,
  parameter logic [7:0] WIDE_OPCODE = 8'hC4,
  parameter int         PC_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 waiting,
  input  logic [7:0]           iram_data,
  input  logic                 iram_valid,
  output logic                 iram_req,
  input  logic [PARAM_LEN-1:0] parameter_number,
  input  logic [ADR_W-1:0]     next_adr,
  output logic [1:0]           state,
  output logic [7:0]           jvm_opcode,
  output logic [ADR_W-1:0]     com_adr,
  output logic                 q_select,
  output logic                 is_wide,
  output logic                 param_valid,
  output logic [7:0]           param_byte,
  output logic [PARAM_LEN:0]   param_idx,
  output logic                 insn_done,
  output logic [PC_W-1:0]      jpc
);

  typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, PARAMS = 2'd2, ITERATE = 2'd3} state_t;

  localparam logic [PARAM_LEN:0] ONE = 1;

  state_t               st;
  logic [PARAM_LEN:0]   target;
  logic [PARAM_LEN:0]   counter;
  logic [PARAM_LEN:0]   dec_target;
  logic                 consume;

  assign state      = st;
  assign iram_req   = (st == FETCH) || (st == PARAMS);
  assign consume    = iram_req & iram_valid & ~waiting;
  // WIDE doubles the operand count; the extra bit keeps the shifted value exact
  assign dec_target = {1'b0, parameter_number} << is_wide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= FETCH;
      jvm_opcode  <= '0;
      com_adr     <= '0;
      q_select    <= 1'b0;
      is_wide     <= 1'b0;
      param_valid <= 1'b0;
      param_byte  <= '0;
      param_idx   <= '0;
      insn_done   <= 1'b0;
      target      <= '0;
      counter     <= '0;
    end else begin
      // pulses last one cycle and are dropped, not replayed, across a stall
      param_valid <= 1'b0;
      insn_done   <= 1'b0;
      if (!waiting) begin
        unique case (st)
          FETCH: if (consume) begin
            jvm_opcode <= iram_data;
            st         <= DECODE;
          end
          DECODE: begin
            if (jvm_opcode == 8'h00) begin
              is_wide   <= 1'b0;
              insn_done <= 1'b1;
              st        <= FETCH;
            end else if (jvm_opcode == WIDE_OPCODE) begin
              is_wide <= 1'b1;
              st      <= FETCH;
            end else begin
              target <= dec_target;
              if (dec_target == '0) begin
                com_adr  <= ADR_W'(jvm_opcode);
                q_select <= 1'b1;
                st       <= ITERATE;
              end else begin
                counter  <= '0;
                q_select <= 1'b0;
                st       <= PARAMS;
              end
            end
          end
          PARAMS: if (consume) begin
            param_valid <= 1'b1;
            param_byte  <= iram_data;
            param_idx   <= counter;
            counter     <= counter + ONE;
            if (counter == target - ONE) begin
              com_adr  <= ADR_W'(jvm_opcode);
              q_select <= 1'b1;
              st       <= ITERATE;
            end
          end
          ITERATE: begin
            if (next_adr == '0) begin
              is_wide   <= 1'b0;
              insn_done <= 1'b1;
              st        <= FETCH;
            end else begin
              com_adr <= next_adr;
            end
          end
        endcase
      end
    end
  end

`ifdef PC_TRACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       jpc <= '0;
    else if (consume) jpc <= jpc + PC_W'(1);
  end
`else
  assign jpc = '0;
`endif

endmodule

// File: tb/tb_jvm_decode_sequencer.sv
// Scoreboard bench for jvm_decode_sequencer: stimulus pushes expected operand
// pulses and retirements; a negedge monitor pops and compares.
module tb_jvm_decode_sequencer;
  localparam int PL = 3;
  localparam int AW = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          waiting = 1'b0;
  logic [7:0]    iram_data = 8'h00;
  logic          iram_valid = 1'b0;
  logic          iram_req;
  logic [PL-1:0] parameter_number;
  logic [AW-1:0] next_adr;
  logic [1:0]    state;
  logic [7:0]    jvm_opcode;
  logic [AW-1:0] com_adr;
  logic          q_select, is_wide, param_valid, insn_done;
  logic [7:0]    param_byte;
  logic [PL:0]   param_idx;
  logic [PW-1:0] jpc;

  always #5 clk = ~clk;

  logic [PL-1:0] pn_rom [256];
  logic [7:0]    nx_rom [256];
  assign parameter_number = pn_rom[jvm_opcode];
  assign next_adr         = nx_rom[com_adr];

  jvm_decode_sequencer #(.PARAM_LEN(PL), .ADR_W(AW), .WIDE_OPCODE(8'hC4), .PC_W(PW)) dut (
    .clk(clk), .reset(reset), .waiting(waiting), .iram_data(iram_data), .iram_valid(iram_valid),
    .iram_req(iram_req), .parameter_number(parameter_number), .next_adr(next_adr), .state(state),
    .jvm_opcode(jvm_opcode), .com_adr(com_adr), .q_select(q_select), .is_wide(is_wide),
    .param_valid(param_valid), .param_byte(param_byte), .param_idx(param_idx),
    .insn_done(insn_done), .jpc(jpc));

  typedef struct { logic [7:0] b; logic [PL:0] idx; logic wide; } pexp_t;
  typedef struct { logic [15:0][7:0] chain; int len; } dexp_t;

  pexp_t      pq[$];
  dexp_t      dq[$];
  logic [7:0] stream[$];
  logic [7:0] fixed_ops[$];
  int checks = 0;
  int fails  = 0;
  int consumed = 0;
  bit drive_en = 1'b0;
  int vprob = 100;
  int wprob = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Reference: an instruction is an optional WIDE prefix, an opcode, pn<<wide
  // operand bytes, then the ROM chain starting at the opcode until a zero link.
  task automatic push_insn(input bit wide, input logic [7:0] op);
    int tgt;
    dexp_t d;
    pexp_t p;
    logic [7:0] a;
    if (wide) stream.push_back(8'hC4);
    stream.push_back(op);
    d.chain = '0;
    d.len   = 0;
    if (op != 8'h00) begin
      tgt = int'(pn_rom[op]) * (wide ? 2 : 1);
      for (int i = 0; i < tgt; i++) begin
        p.b    = (i < fixed_ops.size()) ? fixed_ops[i] : 8'($urandom);
        p.idx  = (PL+1)'(i);
        p.wide = wide;
        stream.push_back(p.b);
        pq.push_back(p);
      end
      a = op;
      while (a != 8'h00 && d.len < 16) begin
        d.chain[d.len] = a;
        d.len++;
        a = nx_rom[a];
      end
    end
    fixed_ops.delete();
    dq.push_back(d);
  endtask

  task automatic init_roms();
    for (int a = 0; a < 256; a++) begin
      pn_rom[a] = ($urandom_range(0, 7) == 0) ? PL'(7) : PL'($urandom_range(0, 3));
      nx_rom[a] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(a >> 1);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_opcode"}, 32'(jvm_opcode), 0);
    chk({tag, "_com_adr"}, 32'(com_adr), 0);
    chk({tag, "_q_select"}, 32'(q_select), 0);
    chk({tag, "_is_wide"}, 32'(is_wide), 0);
    chk({tag, "_param_valid"}, 32'(param_valid), 0);
    chk({tag, "_param_byte"}, 32'(param_byte), 0);
    chk({tag, "_param_idx"}, 32'(param_idx), 0);
    chk({tag, "_insn_done"}, 32'(insn_done), 0);
    chk({tag, "_jpc"}, 32'(jpc), 0);
  endtask

  task automatic chk_jpc();
`ifdef PC_TRACK_EN
    chk("jpc", 32'(jpc), 32'(consumed % (1 << PW)));
`else
    chk("jpc", 32'(jpc), 0);
`endif
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    drive_en = 1'b1;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (stream.size() == 0 && pq.size() == 0 && dq.size() == 0 && state == 2'd0) break;
    end
    if (n == budget) begin
      fails++;
      checks++;
      $display("FAIL idle_timeout: got pending %0d/%0d/%0d expected 0", stream.size(), pq.size(), dq.size());
    end
    repeat (2) @(negedge clk);
    chk_jpc();
  endtask

  // Byte feeder: presents stream head, pops on a consume handshake.
  bit c;
  always begin
    @(negedge clk);
    c = iram_req && iram_valid && !waiting && reset;
    @(posedge clk);
    #1;
    if (c) begin
      if (stream.size() > 0) void'(stream.pop_front());
      consumed++;
    end
    if (drive_en && reset) begin
      iram_valid = (stream.size() > 0) && ($urandom_range(0, 99) < vprob);
      waiting    = ($urandom_range(0, 99) < wprob);
    end else begin
      iram_valid = 1'b0;
      waiting    = 1'b0;
    end
    iram_data = (stream.size() > 0) ? stream[0] : 8'h00;
  end

  // Monitor
  logic [7:0]    trace[$];
  logic [AW-1:0] held_adr = '0;
  logic          pw = 1'b0;
  logic [1:0]    s_st;
  logic [AW-1:0] s_adr;
  logic [7:0]    s_op;
  pexp_t         mp;
  dexp_t         md;

  always @(negedge clk) begin
    if (!reset) begin
      pw = 1'b0;
      trace.delete();
      held_adr = '0;
    end else begin
      if (pw) begin
        chk("stall_state", 32'(state), 32'(s_st));
        chk("stall_com_adr", 32'(com_adr), 32'(s_adr));
        chk("stall_opcode", 32'(jvm_opcode), 32'(s_op));
        chk("stall_pulses", 32'({param_valid, insn_done}), 0);
      end
      if (param_valid) begin
        if (pq.size() == 0) fail_now("param_extra");
        else begin
          mp = pq.pop_front();
          chk("param_byte", 32'(param_byte), 32'(mp.b));
          chk("param_idx", 32'(param_idx), 32'(mp.idx));
          chk("param_wide", 32'(is_wide), 32'(mp.wide));
        end
      end
      if (insn_done) begin
        if (dq.size() == 0) fail_now("done_extra");
        else begin
          md = dq.pop_front();
          chk("chain_len", 32'(trace.size()), 32'(md.len));
          if (trace.size() == md.len)
            for (int i = 0; i < md.len; i++) chk("chain_adr", 32'(trace[i]), 32'(md.chain[i]));
          chk("done_com_adr", 32'(com_adr), 32'(held_adr));
          chk("done_wide_clr", 32'(is_wide), 0);
        end
        trace.delete();
      end
      if (state == 2'd3 && !waiting) begin
        chk("iter_q_select", 32'(q_select), 1);
        trace.push_back(com_adr);
        held_adr = com_adr;
      end
      pw    = waiting;
      s_st  = state;
      s_adr = com_adr;
      s_op  = jvm_opcode;
    end
  end

  logic [7:0] op;
  int n;

  initial begin
    init_roms();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_zero("reset");
    @(negedge clk) reset = 1'b1;

    // bipush 0x7F, chain 0x10 -> 0x21 -> end
    pn_rom[8'h10] = 3'd1; nx_rom[8'h10] = 8'h21; nx_rom[8'h21] = 8'h00;
    fixed_ops = '{8'h7F};
    push_insn(1'b0, 8'h10);
    run_until_idle(500);

    // wide iload 0x01 0x02, then NOP
    pn_rom[8'h15] = 3'd1; nx_rom[8'h15] = 8'h00;
    fixed_ops = '{8'h01, 8'h02};
    push_insn(1'b1, 8'h15);
    push_insn(1'b0, 8'h00);
    run_until_idle(500);

    // iram_valid gap mid-PARAMS and a stall inside ITERATE
    pn_rom[8'h30] = 3'd3; nx_rom[8'h30] = 8'h05; nx_rom[8'h05] = 8'h02;
    nx_rom[8'h02] = 8'h01; nx_rom[8'h01] = 8'h00;
    push_insn(1'b0, 8'h30);
    drive_en = 1'b1;
    for (n = 0; n < 200 && !(state == 2'd2 && param_valid); n++) @(negedge clk);
    if (n == 200) fail_now("wait_params");
    vprob = 0;
    repeat (3) @(negedge clk);
    chk("gap_state", 32'(state), 2);
    vprob = 100;
    for (n = 0; n < 200 && state != 2'd3; n++) @(negedge clk);
    if (n == 200) fail_now("wait_iterate");
    wprob = 100;
    repeat (2) @(negedge clk);
    wprob = 0;
    run_until_idle(500);

    // reset while collecting operands
    pn_rom[8'h40] = 3'd3; nx_rom[8'h40] = 8'h00;
    push_insn(1'b0, 8'h40);
    drive_en = 1'b1;
    for (n = 0; n < 200 && !(state == 2'd2 && param_valid); n++) @(negedge clk);
    if (n == 200) fail_now("wait_params2");
    drive_en = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk_zero("mid_reset");
    stream.delete(); pq.delete(); dq.delete();
    consumed = 0;
    @(negedge clk);
    #1 reset = 1'b1;
    fixed_ops = '{8'h7F};
    push_insn(1'b0, 8'h10);
    run_until_idle(500);

    // randomized traffic with valid gaps and stalls
    init_roms();
    vprob = 75;
    wprob = 15;
    repeat (150) begin
      op = 8'($urandom);
      if (op == 8'hC4) op = 8'h15;
      push_insn($urandom_range(0, 3) == 0, op);
    end
    run_until_idle(40000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/jvm_decode_sequencer.md
Name: jvm_decode_sequencer

Overview:
- Parametrised next-generation JVM bytecode fetch/decode sequencer.
- Consumes bytes from the JVM instruction RAM through a valid/request handshake.
- Recognises NOP and WIDE prefixes, streams operand bytes to the operand queue with an index, then walks the microcode address chain until the chain terminates.
- Sits between the instruction RAM, the parameter-count ROM, the next-address ROM and the ARM-emit datapath.

Parameters:
- PARAM_LEN, 3, width of parameter_number (operand byte count of an opcode).
- ADR_W, 8, width of microcode/next-address ROM address; must be >= 8.
- WIDE_OPCODE, 8'hC4, opcode value treated as the WIDE prefix.
- PC_W, 16, width of jpc (used only when PC_TRACK_EN is defined).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- waiting  in  1  global stall; while 1, no register changes.
- iram_data  in  8  byte from the instruction RAM.
- iram_valid  in  1  iram_data is valid this cycle.
- iram_req  out  1  sequencer requests a byte (FETCH or PARAMS state).
- parameter_number  in  PARAM_LEN  operand count from the param ROM, indexed by jvm_opcode.
- next_adr  in  ADR_W  next-address ROM output, indexed by com_adr.
- state  out  2  current state.
- jvm_opcode  out  8  latched opcode.
- com_adr  out  ADR_W  current microcode address.
- q_select  out  1  0 = Q_FETCH (operand queue), 1 = Q_ITER.
- is_wide  out  1  WIDE prefix pending/applied.
- param_valid  out  1  one-cycle pulse; param_byte and param_idx are valid.
- param_byte  out  8  operand byte.
- param_idx  out  PARAM_LEN+1  operand index, 0-based.
- insn_done  out  1  one-cycle pulse at instruction retirement.
- jpc  out  PC_W  byte program counter (0 when feature is off).

Behaviour:
- Reset (asynchronous, active-low): all outputs and internal registers go to 0; state = FETCH. Takes effect immediately, including mid-instruction; the partial instruction is discarded.
- State encoding: FETCH=0, DECODE=1, PARAMS=2, ITERATE=3.
- Byte consume condition: iram_req & iram_valid & !waiting. With iram_valid=0 the sequencer holds state indefinitely.
- waiting=1 freezes every register. Pulse outputs (param_valid, insn_done) deassert during a stall and are never repeated.
- FETCH: iram_req=1. On consume: jvm_opcode <= iram_data, go to DECODE.
- DECODE (parameter_number is valid for jvm_opcode this cycle):
  - Opcode 0x00 (NOP): is_wide <= 0, insn_done pulse, go to FETCH.
  - Opcode == WIDE_OPCODE: is_wide <= 1, go to FETCH. A repeated WIDE keeps is_wide at 1; there is no double shift.
  - Otherwise target <= parameter_number << is_wide, computed in PARAM_LEN+1 bits (no overflow).
    - target == 0: com_adr <= zero-extended jvm_opcode, q_select <= 1, go to ITERATE.
    - target != 0: counter <= 0, q_select <= 0, go to PARAMS.
- PARAMS: iram_req=1. On each consume:
  - Next cycle: param_valid=1, param_byte = the consumed byte, param_idx = counter. Then counter++.
  - On the consume where counter == target-1: com_adr <= jvm_opcode, q_select <= 1, go to ITERATE.
- ITERATE: each non-stalled cycle:
  - next_adr == 0: is_wide <= 0, insn_done pulse, go to FETCH.
  - next_adr != 0: com_adr <= next_adr.
- Latency: for a 0-operand opcode consumed in cycle N, DECODE is cycle N+1 and ITERATE with com_adr = opcode starts at N+2. Each operand costs one consume cycle.
- q_select and com_adr hold their value in FETCH and DECODE.

Optional Feature:
- Macro: PC_TRACK_EN.
- Defined: jpc increments by 1 on every consumed byte (opcode, WIDE prefix, NOP, operand) and wraps modulo 2^PC_W. It resets to 0 and holds under waiting.
- Not defined: jpc is tied to 0 and no counter logic is built.

Test Plan:
- Reset then byte 0x10 (bipush, parameter_number=1), operand 0x7F, next_adr chain 0x10->0x21->0x00 -> param_valid with byte 0x7F, idx 0; com_adr sequence 0x10, 0x21; insn_done once; return to FETCH.
- Bytes 0xC4, 0x15 (iload, parameter_number=1), operands 0x01, 0x02 -> is_wide=1; two param pulses (idx 0 = 0x01, idx 1 = 0x02); is_wide cleared at retirement.
- Byte 0x00 -> DECODE then FETCH, insn_done pulse, no param_valid, com_adr unchanged.
- iram_valid dropped for 3 cycles mid-PARAMS, and waiting=1 for 2 cycles in ITERATE -> state, counter and com_adr hold; no duplicate pulses.
- reset asserted while in PARAMS -> all outputs 0 and state=FETCH immediately; the next opcode decodes cleanly.
- With PC_TRACK_EN, sequence 0xC4, 0x15, 0x01, 0x02, 0x00 -> jpc=5. With PC_W=4 and 17 bytes consumed -> jpc=1 (wrap).
